// File: rtl/sw_ctrl_seq.sv
// sw_ctrl_seq: per-channel switch sync/debounce/mode shaping plus a timed
// ASIC reset / clock-enable power-up sequencer triggered by one channel.
module sw_ctrl_seq #(
    parameter int NUM_SW     = 4,
    parameter int CNT_W      = 16,
    parameter int DEB_CYCLES = 100,
    parameter int SEQ_CH     = 0,
    parameter int RST_CYCLES = 200,
    parameter int GATE_DLY   = 10,
    parameter int RUN_CYCLES = 0
) (
    input  logic                I_clk,
    input  logic                I_rst_n,
    input  logic [NUM_SW-1:0]   I_sw,
    input  logic [2*NUM_SW-1:0] I_mode,
    output logic [NUM_SW-1:0]   O_sw_level,
    output logic [NUM_SW-1:0]   O_sw_out,
    output logic                O_reset_n,
    output logic                O_clk_en,
    output logic                O_seq_busy,
    output logic [1:0]          O_seq_state
);
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    if (CNT_W < 1 || CNT_W > 62) $error("sw_ctrl_seq: CNT_W out of range");
    if (NUM_SW < 1 || SEQ_CH < 0 || SEQ_CH >= NUM_SW) $error("sw_ctrl_seq: NUM_SW/SEQ_CH out of range");
    if (DEB_CYCLES < 1 || DEB_CYCLES > CNT_MAX) $error("sw_ctrl_seq: DEB_CYCLES out of range");
    if (RST_CYCLES < 1 || RST_CYCLES > CNT_MAX) $error("sw_ctrl_seq: RST_CYCLES out of range");
    if (GATE_DLY < 1 || GATE_DLY > CNT_MAX) $error("sw_ctrl_seq: GATE_DLY out of range");
    if (RUN_CYCLES < 0 || RUN_CYCLES > CNT_MAX) $error("sw_ctrl_seq: RUN_CYCLES out of range");

    localparam logic [CNT_W-1:0] DEB_M1  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_M1  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GATE_M1 = CNT_W'(GATE_DLY - 1);
    localparam logic [CNT_W-1:0] RUN_M1  = CNT_W'(RUN_CYCLES > 0 ? RUN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_RST = 2'b01, S_WAIT = 2'b10, S_RUN = 2'b11} state_t;

    logic [NUM_SW-1:0] r_sync1, r_sync2, r_level, r_tog, r_out;
    logic [CNT_W-1:0]  r_deb_cnt [NUM_SW];
    logic [CNT_W-1:0]  w_deb_cnt [NUM_SW];
    logic [NUM_SW-1:0] w_level, w_rise, w_fall, w_tog, w_out;

    // Shaped outputs are computed from the next level so they move on the same edge.
    always_comb begin
        for (int i = 0; i < NUM_SW; i++) begin
            w_deb_cnt[i] = '0;
            w_level[i]   = r_level[i];
            if (r_sync2[i] != r_level[i]) begin
                if (r_deb_cnt[i] == DEB_M1) w_level[i] = r_sync2[i];
                else w_deb_cnt[i] = r_deb_cnt[i] + CNT_W'(1);
            end
        end
    end

    assign w_rise = w_level & ~r_level;
    assign w_fall = ~w_level & r_level;
    assign w_tog  = r_tog ^ w_rise;

    always_comb begin
        for (int i = 0; i < NUM_SW; i++)
            w_out[i] = I_mode[2*i+1] ? (I_mode[2*i] ? w_fall[i] : w_rise[i])
                                     : (I_mode[2*i] ? w_tog[i]  : w_level[i]);
    end

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_seq_cnt, w_seq_cnt, w_dec;
    logic             r_trig, r_reset_n, r_clk_en, w_reset_n, w_clk_en, w_done;

    assign w_done = r_seq_cnt == '0;
    assign w_dec  = r_seq_cnt - CNT_W'(1);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_tog     <= '0;
            r_out     <= '0;
            r_trig    <= 1'b0;
            for (int i = 0; i < NUM_SW; i++) r_deb_cnt[i] <= '0;
            r_state   <= S_IDLE;
            r_seq_cnt <= '0;
            r_reset_n <= 1'b0;
            r_clk_en  <= 1'b0;
        end else begin
            r_sync1   <= I_sw;
            r_sync2   <= r_sync1;
            r_level   <= w_level;
            r_tog     <= w_tog;
            r_out     <= w_out;
            r_trig    <= w_rise[SEQ_CH];
            for (int i = 0; i < NUM_SW; i++) r_deb_cnt[i] <= w_deb_cnt[i];
            r_state   <= w_state;
            r_seq_cnt <= w_seq_cnt;
            r_reset_n <= w_reset_n;
            r_clk_en  <= w_clk_en;
        end
    end

    // A trigger in any state restarts the sequence with a fresh reset count.
    always_comb begin
        w_state   = r_state;
        w_seq_cnt = r_seq_cnt;
        if (r_trig) begin
            w_state   = S_RST;
            w_seq_cnt = RST_M1;
        end else begin
            case (r_state)
                S_RST: begin
                    w_state   = w_done ? S_WAIT : S_RST;
                    w_seq_cnt = w_done ? GATE_M1 : w_dec;
                end
                S_WAIT: begin
                    w_state   = w_done ? S_RUN : S_WAIT;
                    w_seq_cnt = w_done ? RUN_M1 : w_dec;
                end
                S_RUN: begin
                    if (RUN_CYCLES > 0) begin
                        w_state   = w_done ? S_IDLE : S_RUN;
                        w_seq_cnt = w_done ? r_seq_cnt : w_dec;
                    end
                end
                default: ;
            endcase
        end
        w_reset_n = (w_state == S_IDLE) ? r_reset_n : (w_state != S_RST);
        w_clk_en  = w_state == S_RUN;
    end

    assign O_sw_level  = r_level;
    assign O_sw_out    = r_out;
    assign O_reset_n   = r_reset_n;
    assign O_clk_en    = r_clk_en;
    assign O_seq_busy  = r_state != S_IDLE;
    assign O_seq_state = r_state;
endmodule

// File: tb/tb_sw_ctrl_seq.sv
// tb_sw_ctrl_seq: scoreboard bench; expected values are timestamped at
// stimulus time and checked when the clock reaches that cycle.
module tb_sw_ctrl_seq;
    localparam int S_LVL = 0, S_OUT = 1, S_RN = 2, S_CE = 3, S_ST = 4, S_BSY = 5;
    localparam int S_RN0 = 6, S_CE0 = 7, S_ST0 = 8, S_BSY0 = 9;

    typedef struct {
        int          cyc;
        int          sig;
        logic [15:0] val;
        string       tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic [7:0] mode;
    logic [3:0] lvl, out, lvl0, out0;
    logic       rn, ce, bsy, rn0, ce0, bsy0;
    logic [1:0] st, st0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    exp_t       q[$];

    sw_ctrl_seq #(.NUM_SW(4), .CNT_W(16), .DEB_CYCLES(4), .SEQ_CH(0),
                  .RST_CYCLES(5), .GATE_DLY(3), .RUN_CYCLES(4)) u_dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_sw(sw), .I_mode(mode),
        .O_sw_level(lvl), .O_sw_out(out), .O_reset_n(rn), .O_clk_en(ce),
        .O_seq_busy(bsy), .O_seq_state(st));

    sw_ctrl_seq #(.NUM_SW(4), .CNT_W(16), .DEB_CYCLES(4), .SEQ_CH(0),
                  .RST_CYCLES(5), .GATE_DLY(3), .RUN_CYCLES(0)) u_dut0 (
        .I_clk(clk), .I_rst_n(rst_n), .I_sw(sw), .I_mode(mode),
        .O_sw_level(lvl0), .O_sw_out(out0), .O_reset_n(rn0), .O_clk_en(ce0),
        .O_seq_busy(bsy0), .O_seq_state(st0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] obs(int s);
        case (s)
            S_LVL:  return 16'(lvl);
            S_OUT:  return 16'(out);
            S_RN:   return 16'(rn);
            S_CE:   return 16'(ce);
            S_ST:   return 16'(st);
            S_BSY:  return 16'(bsy);
            S_RN0:  return 16'(rn0);
            S_CE0:  return 16'(ce0);
            S_ST0:  return 16'(st0);
            S_BSY0: return 16'(bsy0);
            default: return 16'hffff;
        endcase
    endfunction

    function automatic void want(int c, int s, logic [15:0] v, string tag);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        e.tag = tag;
        q.push_back(e);
    endfunction

    function automatic void sq(int c, int which, int s, int r, int e);
        want(c, which ? S_ST0 : S_ST, 16'(s), which ? "state0" : "state");
        want(c, which ? S_RN0 : S_RN, 16'(r), which ? "reset_n0" : "reset_n");
        want(c, which ? S_CE0 : S_CE, 16'(e), which ? "clk_en0" : "clk_en");
        want(c, which ? S_BSY0 : S_BSY, 16'(s != 0), which ? "busy0" : "busy");
    endfunction

    function automatic void sq2(int c, int s, int r, int e);
        sq(c, 0, s, r, e);
        sq(c, 1, s, r, e);
    endfunction

    // Outputs are sampled on the falling edge, half a period after each active edge.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                chk($sformatf("%s@%0d", q[i].tag, cyc), obs(q[i].sig), q[i].val);
                q.delete(i);
            end
        end
    end

    task automatic goto(int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int   k, t2, t3, r;
        logic tog, tn;
        rst_n = 1'b0;
        sw    = 4'h0;
        mode  = 8'b11_10_01_00;
        repeat (3) @(negedge clk);
        chk("rst_level", 16'(lvl), 16'h0);
        chk("rst_out", 16'(out), 16'h0);
        chk("rst_reset_n", 16'(rn), 16'h0);
        chk("rst_clk_en", 16'(ce), 16'h0);
        chk("rst_state", 16'(st), 16'h0);
        chk("rst_busy", 16'(bsy), 16'h0);
        rst_n = 1'b1;

        k = cyc + 2;
        for (int c = k + 1; c <= k + 12; c++) begin
            want(c, S_LVL, 16'h0, "glitch_level");
            want(c, S_OUT, 16'h0, "glitch_out");
        end
        sq2(k + 12, 0, 0, 0);
        goto(k);
        sw = 4'b0010;
        goto(k + 3);
        sw = 4'b0000;

        k   = k + 14;
        tog = 1'b0;
        for (int p = 0; p < 3; p++) begin
            goto(k);
            sw = 4'hF;
            tn = ~tog;
            want(k + 5, S_LVL, 16'h0, "press_level_early");
            want(k + 5, S_OUT, 16'({2'b00, tog, 1'b0}), "press_out_early");
            want(k + 6, S_LVL, 16'hF, "press_level");
            want(k + 6, S_OUT, 16'({2'b01, tn, 1'b1}), "press_out");
            want(k + 7, S_OUT, 16'({2'b00, tn, 1'b1}), "press_out_after");
            tog = tn;
            goto(k + 10);
            sw = 4'h0;
            want(k + 15, S_LVL, 16'hF, "release_level_early");
            want(k + 15, S_OUT, 16'({2'b00, tog, 1'b1}), "release_out_early");
            want(k + 16, S_LVL, 16'h0, "release_level");
            want(k + 16, S_OUT, 16'({2'b10, tog, 1'b0}), "release_out");
            want(k + 17, S_OUT, 16'({2'b00, tog, 1'b0}), "release_out_after");
            k = k + 20;
        end

        k  = k + 30;
        t2 = k + 6;
        t3 = k + 14;
        sq(t2, 0, 0, 1, 0);
        sq(t2, 1, 3, 1, 1);
        for (int c = t2 + 1; c <= t2 + 5; c++) sq2(c, 1, 0, 0);
        for (int c = t2 + 6; c <= t2 + 8; c++) sq2(c, 2, 1, 0);
        for (int c = t3 + 1; c <= t3 + 5; c++) sq2(c, 1, 0, 0);
        for (int c = t3 + 6; c <= t3 + 8; c++) sq2(c, 2, 1, 0);
        for (int c = t3 + 9; c <= t3 + 12; c++) sq2(c, 3, 1, 1);
        for (int c = t3 + 13; c <= t3 + 20; c++) begin
            sq(c, 0, 0, 1, 0);
            sq(c, 1, 3, 1, 1);
        end
        goto(k);
        sw = 4'b0001;
        goto(k + 4);
        sw = 4'b0000;
        goto(k + 8);
        sw = 4'b0001;

        goto(t3 + 21);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_reset_n", 16'(rn), 16'h0);
        chk("arst_clk_en", 16'(ce), 16'h0);
        chk("arst_out", 16'(out), 16'h0);
        chk("arst_state", 16'(st), 16'h0);
        chk("arst_reset_n0", 16'(rn0), 16'h0);
        chk("arst_clk_en0", 16'(ce0), 16'h0);
        chk("arst_out0", 16'(out0), 16'h0);
        chk("arst_level0", 16'(lvl0), 16'h0);
        chk("arst_busy0", 16'(bsy0), 16'h0);
        @(negedge clk);
        r = cyc;
        rst_n = 1'b1;
        for (int c = r + 1; c <= r + 6; c++) begin
            sq2(c, 0, 0, 0);
            want(c, S_LVL, (c == r + 6) ? 16'h1 : 16'h0, "rearm_level");
        end
        for (int c = r + 7; c <= r + 11; c++) sq2(c, 1, 0, 0);
        sq2(r + 12, 2, 1, 0);

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        chk("drain", 16'(q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
